// File: rtl/contour_pkg.sv
// Shared definitions for the contour tracer and the bin reader: image geometry,
// bus widths, the bin result record and the reader state encoding.
package contour_pkg;

    localparam int WIDTH   = 640;
    localparam int HEIGHT  = 480;
    localparam int ADDR_W  = 19;
    localparam int BIN_W   = 3;
    localparam int SUM_W   = 28;
    localparam int COUNT_W = 19;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int BBOX_W  = 2 * (X_W + Y_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_EMIT,
        ST_DONE
    } reader_state_e;

    typedef struct packed {
        logic [BIN_W-1:0]   id;
        logic [COUNT_W-1:0] count;
        logic [SUM_W-1:0]   sum_x;
        logic [SUM_W-1:0]   sum_y;
    } bin_rec_t;

    typedef struct packed {
        logic           valid;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pix_tag_t;

endpackage

// File: rtl/contour_tag_pipe.sv
// Delays the {valid, x, y} tag of each issued address by READ_LATENCY cycles so it
// lines up with the BRAM read data for that address.
module contour_tag_pipe
    import contour_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  pix_tag_t tag_i,
    output pix_tag_t tag_o
);

    pix_tag_t stage_q [READ_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/contour_bin_reader.sv
// Scans the bin-label BRAM, accumulates per-bin count and x/y sums, then streams one
// record per bin over valid/ready. Define CONTOUR_BBOX_EN to add per-bin bounding boxes.
module contour_bin_reader
    import contour_pkg::*;
#(
    parameter int WIDTH        = contour_pkg::WIDTH,
    parameter int HEIGHT       = contour_pkg::HEIGHT,
    parameter int READ_LATENCY = 2,
    parameter int NUM_BINS     = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  edge_addr_read,
    input  logic [BIN_W-1:0]   bram_read,
    output logic               bin_valid,
    input  logic               bin_ready,
    output logic [BIN_W-1:0]   bin_id,
    output logic [COUNT_W-1:0] bin_count,
    output logic [SUM_W-1:0]   bin_sum_x,
    output logic [SUM_W-1:0]   bin_sum_y
`ifdef CONTOUR_BBOX_EN
    ,
    output logic [BBOX_W-1:0]  bin_bbox
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [X_W-1:0]    LAST_X     = X_W'(WIDTH - 1);
    localparam logic [3:0]        DRAIN_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [BIN_W-1:0]  LAST_BIN   = BIN_W'(NUM_BINS);

    reader_state_e      state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [3:0]         drain_q, drain_d;
    logic [BIN_W-1:0]   id_q, id_d;
    logic               clear_acc;

    pix_tag_t           tag_in, tag_out;
    logic               hit;

    logic [COUNT_W-1:0] count_q [NUM_BINS];
    logic [SUM_W-1:0]   sum_x_q [NUM_BINS];
    logic [SUM_W-1:0]   sum_y_q [NUM_BINS];
    bin_rec_t           rec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            drain_q <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            drain_q <= drain_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        x_d       = x_q;
        y_d       = y_q;
        drain_d   = drain_q;
        id_d      = id_q;
        clear_acc = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_SCAN;
                    addr_d    = '0;
                    x_d       = '0;
                    y_d       = '0;
                    id_d      = '0;
                    clear_acc = 1'b1;
                end
            end
            ST_SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (x_q == LAST_X) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_EMIT;
                    id_d    = 1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_EMIT: begin
                if (bin_ready) begin
                    if (id_q == LAST_BIN) begin
                        state_d = ST_DONE;
                        id_d    = '0;
                    end else begin
                        id_d = id_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tag_in = '{valid: (state_q == ST_SCAN), x: x_q, y: y_q};

    contour_tag_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Labels above NUM_BINS are dropped along with background zeros.
    assign hit = tag_out.valid && (bram_read != '0) && (bram_read <= LAST_BIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BINS; b++) begin
                count_q[b] <= '0;
                sum_x_q[b] <= '0;
                sum_y_q[b] <= '0;
            end
        end else if (clear_acc) begin
            for (int b = 0; b < NUM_BINS; b++) begin
                count_q[b] <= '0;
                sum_x_q[b] <= '0;
                sum_y_q[b] <= '0;
            end
        end else if (hit) begin
            for (int b = 0; b < NUM_BINS; b++) begin
                if (bram_read == BIN_W'(b + 1)) begin
                    count_q[b] <= count_q[b] + 1'b1;
                    sum_x_q[b] <= sum_x_q[b] + SUM_W'(tag_out.x);
                    sum_y_q[b] <= sum_y_q[b] + SUM_W'(tag_out.y);
                end
            end
        end
    end

    // Accumulators are frozen during EMIT, so selecting them by the registered
    // bin index gives stable record fields while the consumer stalls.
    always_comb begin
        rec = '0;
        for (int b = 0; b < NUM_BINS; b++) begin
            if (id_q == BIN_W'(b + 1)) begin
                rec.id    = id_q;
                rec.count = count_q[b];
                rec.sum_x = sum_x_q[b];
                rec.sum_y = sum_y_q[b];
            end
        end
    end

`ifdef CONTOUR_BBOX_EN
    logic [X_W-1:0] min_x_q [NUM_BINS];
    logic [Y_W-1:0] min_y_q [NUM_BINS];
    logic [X_W-1:0] max_x_q [NUM_BINS];
    logic [Y_W-1:0] max_y_q [NUM_BINS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BINS; b++) begin
                min_x_q[b] <= '1;
                min_y_q[b] <= '1;
                max_x_q[b] <= '0;
                max_y_q[b] <= '0;
            end
        end else if (clear_acc) begin
            for (int b = 0; b < NUM_BINS; b++) begin
                min_x_q[b] <= '1;
                min_y_q[b] <= '1;
                max_x_q[b] <= '0;
                max_y_q[b] <= '0;
            end
        end else if (hit) begin
            for (int b = 0; b < NUM_BINS; b++) begin
                if (bram_read == BIN_W'(b + 1)) begin
                    if (tag_out.x < min_x_q[b]) min_x_q[b] <= tag_out.x;
                    if (tag_out.y < min_y_q[b]) min_y_q[b] <= tag_out.y;
                    if (tag_out.x > max_x_q[b]) max_x_q[b] <= tag_out.x;
                    if (tag_out.y > max_y_q[b]) max_y_q[b] <= tag_out.y;
                end
            end
        end
    end

    always_comb begin
        bin_bbox = '0;
        for (int b = 0; b < NUM_BINS; b++) begin
            if (id_q == BIN_W'(b + 1)) begin
                bin_bbox = {min_x_q[b], min_y_q[b], max_x_q[b], max_y_q[b]};
            end
        end
    end
`endif

    assign busy           = (state_q == ST_SCAN) || (state_q == ST_DRAIN) || (state_q == ST_EMIT);
    assign done           = (state_q == ST_DONE);
    assign bin_valid      = (state_q == ST_EMIT);
    assign edge_addr_read = addr_q;
    assign bin_id         = rec.id;
    assign bin_count      = rec.count;
    assign bin_sum_x      = rec.sum_x;
    assign bin_sum_y      = rec.sum_y;

endmodule

// File: tb/tb_contour_bin_reader.sv
// Scoreboard bench for contour_bin_reader on a reduced 16x8 image; a behavioural BRAM
// with two-cycle read latency feeds the DUT and a reference model predicts each record.
`timescale 1ns/1ps
module tb_contour_bin_reader;
    import contour_pkg::*;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int N  = W * H;
    localparam int NB = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, bin_valid;
    logic        bin_ready = 1'b1;
    logic [18:0] edge_addr_read;
    logic [2:0]  bram_read, bin_id;
    logic [18:0] bin_count;
    logic [27:0] bin_sum_x, bin_sum_y;
`ifdef CONTOUR_BBOX_EN
    logic [37:0] bin_bbox;
`endif

    logic [2:0] mem [N];
    logic [2:0] rd1 = '0;
    logic [2:0] rd2 = '0;

    typedef struct {
        logic [2:0]  id;
        logic [18:0] cnt;
        logic [27:0] sx;
        logic [27:0] sy;
        logic [37:0] bb;
    } rec_t;

    rec_t exp_q[$];
    rec_t r;
    int   checks = 0;
    int   errors = 0;
    int   stall_left = 0;
    int   emit_cycles = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd1 <= (int'(edge_addr_read) < N) ? mem[int'(edge_addr_read)] : 3'd0;
        rd2 <= rd1;
    end
    assign bram_read = rd2;

    contour_bin_reader #(
        .WIDTH(W),
        .HEIGHT(H),
        .READ_LATENCY(2),
        .NUM_BINS(NB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .edge_addr_read (edge_addr_read),
        .bram_read      (bram_read),
        .bin_valid      (bin_valid),
        .bin_ready      (bin_ready),
        .bin_id         (bin_id),
        .bin_count      (bin_count),
        .bin_sum_x      (bin_sum_x),
        .bin_sum_y      (bin_sum_y)
`ifdef CONTOUR_BBOX_EN
        ,
        .bin_bbox       (bin_bbox)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives bin_ready and pops/compares the scoreboard on every handshake.
    always @(negedge clk) begin
        if (rst) begin
            bin_ready = 1'b1;
        end else if (bin_valid) begin
            emit_cycles++;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 64'(exp_q.size()), 64'(1));
                bin_ready = 1'b1;
            end else if (stall_left > 0 && bin_id == 3'd3) begin
                bin_ready = 1'b0;
                stall_left--;
                chk("hold_id",  64'(bin_id),    64'(exp_q[0].id));
                chk("hold_cnt", 64'(bin_count), 64'(exp_q[0].cnt));
                chk("hold_sx",  64'(bin_sum_x), 64'(exp_q[0].sx));
                chk("hold_sy",  64'(bin_sum_y), 64'(exp_q[0].sy));
            end else begin
                bin_ready = 1'b1;
                r = exp_q.pop_front();
                chk("rec_id",  64'(bin_id),    64'(r.id));
                chk("rec_cnt", 64'(bin_count), 64'(r.cnt));
                chk("rec_sx",  64'(bin_sum_x), 64'(r.sx));
                chk("rec_sy",  64'(bin_sum_y), 64'(r.sy));
`ifdef CONTOUR_BBOX_EN
                chk("rec_bbox", 64'(bin_bbox), 64'(r.bb));
`endif
            end
        end else begin
            bin_ready = 1'b1;
        end
    end

    task automatic push_model();
        rec_t m [NB];
        for (int b = 0; b < NB; b++) begin
            m[b].id  = 3'(b + 1);
            m[b].cnt = '0;
            m[b].sx  = '0;
            m[b].sy  = '0;
            m[b].bb  = {10'h3FF, 9'h1FF, 10'd0, 9'd0};
        end
        for (int a = 0; a < N; a++) begin
            int b, x, y;
            b = int'(mem[a]);
            x = a % W;
            y = a / W;
            if (b >= 1 && b <= NB) begin
                m[b-1].cnt = m[b-1].cnt + 19'd1;
                m[b-1].sx  = m[b-1].sx + 28'(x);
                m[b-1].sy  = m[b-1].sy + 28'(y);
                if (10'(x) < m[b-1].bb[37:28]) m[b-1].bb[37:28] = 10'(x);
                if (9'(y)  < m[b-1].bb[27:19]) m[b-1].bb[27:19] = 9'(y);
                if (10'(x) > m[b-1].bb[18:9])  m[b-1].bb[18:9]  = 10'(x);
                if (9'(y)  > m[b-1].bb[8:0])   m[b-1].bb[8:0]   = 9'(y);
            end
        end
        for (int b = 0; b < NB; b++) exp_q.push_back(m[b]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_scan(input int stall, input bit inject);
        int c;
        push_model();
        emit_cycles = 0;
        stall_left  = stall;
        pulse_start();
        chk("c1_busy", 64'(busy), 64'(1));
        chk("c1_addr", 64'(edge_addr_read), 64'(0));
        chk("c1_done", 64'(done), 64'(0));
        c = 1;
        while (!done && c < N + 200) begin
            @(negedge clk);
            c++;
            if (inject && c == N + 5) start = 1'b1;
            if (inject && c == N + 6) start = 1'b0;
        end
        start = 1'b0;
        chk("done_cycle", 64'(c), 64'(N + 10 + stall));
        chk("end_busy",   64'(busy), 64'(0));
        chk("end_valid",  64'(bin_valid), 64'(0));
        chk("sb_left",    64'(exp_q.size()), 64'(0));
        chk("emit_len",   64'(emit_cycles), 64'(NB + stall));
    endtask

    task automatic clear_mem();
        for (int a = 0; a < N; a++) mem[a] = 3'd0;
    endtask

    initial begin
        int g;
        rst   = 1'b1;
        start = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",  64'(busy), 64'(0));
        chk("rst_done",  64'(done), 64'(0));
        chk("rst_addr",  64'(edge_addr_read), 64'(0));
        chk("rst_valid", 64'(bin_valid), 64'(0));
        chk("rst_id",    64'(bin_id), 64'(0));
        chk("rst_cnt",   64'(bin_count), 64'(0));
        chk("rst_sx",    64'(bin_sum_x), 64'(0));
        chk("rst_sy",    64'(bin_sum_y), 64'(0));
`ifdef CONTOUR_BBOX_EN
        chk("rst_bbox",  64'(bin_bbox), 64'(0));
`endif

        // all-zero memory
        run_scan(0, 1'b0);

        // single label 3 at (5,2)
        mem[2*W + 5] = 3'd3;
        run_scan(0, 1'b0);

        // bottom row labelled 7
        clear_mem();
        for (int x = 0; x < W; x++) mem[(H-1)*W + x] = 3'd7;
        run_scan(0, 1'b0);

        // stall on bin 3 for ten cycles, start pulsed during EMIT
        clear_mem();
        mem[2*W + 5] = 3'd3;
        run_scan(10, 1'b1);

        // random labels, reset mid-scan, then a clean rescan
        for (int a = 0; a < N; a++) mem[a] = 3'($urandom_range(0, 7));
        pulse_start();
        g = 0;
        while (edge_addr_read != 19'd100 && g < N) begin
            @(negedge clk);
            g++;
        end
        chk("rst_reach", 64'(edge_addr_read), 64'(100));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_busy",  64'(busy), 64'(0));
        chk("mid_addr",  64'(edge_addr_read), 64'(0));
        chk("mid_valid", 64'(bin_valid), 64'(0));
        chk("mid_done",  64'(done), 64'(0));
        chk("mid_cnt",   64'(bin_count), 64'(0));
        exp_q.delete();
        rst = 1'b0;
        run_scan(0, 1'b0);

        // two-point bin 2 with every other bin empty
        clear_mem();
        mem[1*W + 3]  = 3'd2;
        mem[6*W + 12] = 3'd2;
        run_scan(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
